// File: rtl/parity_arbiter_pkg.sv
// parity_arbiter_pkg: shared constants for the parity arbiter slice.
//   - FSM state encoding (IDLE / EVAL / HOLD)
//   - requester ID constants (REQ0 / REQ1)
//   - default widths for the checked word and the error counter
package parity_arbiter_pkg;

   localparam int DEF_DATA_W    = 9;
   localparam int DEF_ERR_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage : parity_arbiter_pkg

// File: rtl/parity_arbiter_eval.sv
// parity_eval: purely combinational ones-parity evaluator (74HC280 function).
//   data  : DATA_W-bit word
//   even  : word has an even number of 1s
//   odd   : word has an odd number of 1s (always ~even)
module parity_eval #(
   parameter int DATA_W = 9
) (
   input  logic [DATA_W-1:0] data,
   output logic              even,
   output logic              odd
);

   assign odd  = ^data;
   assign even = ~odd;

endmodule : parity_eval

// File: rtl/parity_arbiter.sv
// parity_arbiter: shares one parity_eval between two requesters with
// round-robin arbitration. A granted word is captured in IDLE, evaluated in
// EVAL, and its result is held in HOLD until the consumer takes it.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid/data/odd/ready      requester N word + expected parity sense
//   res_valid/res_ready            result handshake
//   res_id, res_even, res_odd      result owner and observed parity flags
//   res_err                        observed parity differs from expected sense
//   err_count                      saturating count of results with res_err=1
//
// Build option: define PARITY_ERR_CNT_EN to build the error counter; without
// it err_count is tied to 0.
module parity_arbiter
   import parity_arbiter_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   input  logic [DATA_W-1:0]    req0_data,
   input  logic                 req0_odd,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [DATA_W-1:0]    req1_data,
   input  logic                 req1_odd,
   output logic                 req1_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 res_id,
   output logic                 res_even,
   output logic                 res_odd,
   output logic                 res_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   state_t              state;
   logic                ptr;       // preferred requester
   logic                grant_vld;
   logic                grant_id;
   logic                accept;
   logic [DATA_W-1:0]   cap_data;
   logic                cap_odd;
   logic                cap_id;
   logic                obs_even;
   logic                obs_odd;
   logic                mismatch;

   // Round-robin grant: preferred requester first, else the other one.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = ptr;
      if (ptr == REQ0) begin
         if (req0_valid)      begin grant_vld = 1'b1; grant_id = REQ0; end
         else if (req1_valid) begin grant_vld = 1'b1; grant_id = REQ1; end
      end else begin
         if (req1_valid)      begin grant_vld = 1'b1; grant_id = REQ1; end
         else if (req0_valid) begin grant_vld = 1'b1; grant_id = REQ0; end
      end
   end

   // Readys are masked during reset so no word is taken while rst is high.
   assign accept     = (state == IDLE) & grant_vld & ~rst;
   assign req0_ready = accept & (grant_id == REQ0);
   assign req1_ready = accept & (grant_id == REQ1);

   // The single shared evaluator, fed from the captured word.
   parity_eval #(.DATA_W(DATA_W)) u_eval (
      .data (cap_data),
      .even (obs_even),
      .odd  (obs_odd)
   );

   assign mismatch = obs_odd ^ cap_odd;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= REQ0;
         cap_data  <= '0;
         cap_odd   <= 1'b0;
         cap_id    <= REQ0;
         res_valid <= 1'b0;
         res_id    <= REQ0;
         res_even  <= 1'b1;
         res_odd   <= 1'b0;
         res_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  cap_data <= (grant_id == REQ1) ? req1_data : req0_data;
                  cap_odd  <= (grant_id == REQ1) ? req1_odd  : req0_odd;
                  cap_id   <= grant_id;
                  state    <= EVAL;
               end
            end
            EVAL: begin
               res_even  <= obs_even;
               res_odd   <= obs_odd;
               res_err   <= mismatch;
               res_id    <= cap_id;
               res_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  ptr       <= ~res_id;   // favour the requester not just served
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PARITY_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q;

   // Counts alongside the EVAL result register; sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst)
         err_cnt_q <= '0;
      else if ((state == EVAL) && mismatch && (err_cnt_q != '1))
         err_cnt_q <= err_cnt_q + 1'b1;
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

endmodule : parity_arbiter

// File: tb/tb_parity_arbiter.sv
// tb_parity_arbiter: directed bench for parity_arbiter (ERR_CNT_W=2 so the
// counter saturates quickly when PARITY_ERR_CNT_EN is defined).
module tb_parity_arbiter;

   localparam int DW = 9;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_odd, req0_ready;
   logic [DW-1:0] req0_data;
   logic          req1_valid, req1_odd, req1_ready;
   logic [DW-1:0] req1_data;
   logic          res_valid, res_ready, res_id, res_even, res_odd, res_err;
   logic [CW-1:0] err_count;

   int n_vec  = 0;
   int n_miss = 0;
   int mcnt   = 0;   // expected err_count

   always #5 clk = ~clk;

   parity_arbiter #(.DATA_W(DW), .ERR_CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_odd   (req0_odd),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_odd   (req1_odd),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_id     (res_id),
      .res_even   (res_even),
      .res_odd    (res_odd),
      .res_err    (res_err),
      .err_count  (err_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_cnt();
`ifdef PARITY_ERR_CNT_EN
      return mcnt;
`else
      return 0;
`endif
   endfunction

   task automatic note_err(input logic e);
      if (e && mcnt < (1 << CW) - 1) mcnt++;
   endtask

   // One word from requester `id` (other requester idle), res_ready held high.
   task automatic send(input string tag, input logic id, input logic [DW-1:0] d,
                       input logic o, input logic e_odd, input logic e_err);
      res_ready = 1'b1;
      if (id) begin req1_valid = 1'b1; req1_data = d; req1_odd = o; end
      else    begin req0_valid = 1'b1; req0_data = d; req0_odd = o; end
      #1;
      chk({tag, ".ready0"}, req0_ready, !id);
      chk({tag, ".ready1"}, req1_ready, id);
      tick();                               // accept edge
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk({tag, ".eval_valid"}, res_valid, 1'b0);
      tick();                               // EVAL edge -> HOLD
      note_err(e_err);
      chk({tag, ".valid"}, res_valid, 1'b1);
      chk({tag, ".id"},    res_id,    id);
      chk({tag, ".odd"},   res_odd,   e_odd);
      chk({tag, ".even"},  res_even,  !e_odd);
      chk({tag, ".err"},   res_err,   e_err);
      chk({tag, ".cnt"},   err_count, exp_cnt());
      tick();                               // HOLD handshake -> IDLE
      chk({tag, ".done"},  res_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_data = '0; req0_odd = 1'b0;
      req1_valid = 1'b0; req1_data = '0; req1_odd = 1'b0;
      res_ready = 1'b0;
      tick(); tick();

      // Reset state (valids high to show readys are masked)
      req0_valid = 1'b1; req1_valid = 1'b1; #1;
      chk("rst.valid", res_valid, 1'b0);
      chk("rst.id",    res_id,    1'b0);
      chk("rst.even",  res_even,  1'b1);
      chk("rst.odd",   res_odd,   1'b0);
      chk("rst.err",   res_err,   1'b0);
      chk("rst.cnt",   err_count, 0);
      chk("rst.rdy0",  req0_ready, 1'b0);
      chk("rst.rdy1",  req1_ready, 1'b0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b0;

      // Basic words: one 1 with odd expected; nine 1s with even expected; zero
      send("w001", 1'b0, 9'h001, 1'b1, 1'b1, 1'b0);
      send("w1ff", 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b1);
      send("w000", 1'b1, 9'h000, 1'b0, 1'b0, 1'b0);

      // Continuous demand: pointer is 0 here, expect grants 0,1,0,1
      req0_data = 9'h003; req0_odd = 1'b0;
      req1_data = 9'h007; req1_odd = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr.rdy0", req0_ready, (k % 2) == 0);
         chk("rr.rdy1", req1_ready, (k % 2) == 1);
         tick();
         chk("rr.eval_rdy", {req0_ready, req1_ready}, 2'b00);
         tick();
         chk("rr.id",  res_id,  (k % 2) == 1);
         chk("rr.err", res_err, 1'b0);
         chk("rr.hold_rdy", {req0_ready, req1_ready}, 2'b00);
         tick();
      end

      // Stalled HOLD: req0 wins (pointer back at 0), req1 keeps waiting
      req0_data = 9'h0F0; req0_odd = 1'b1;
      res_ready = 1'b0; #1;
      chk("st.rdy0", req0_ready, 1'b1);
      tick();
      req0_valid = 1'b0;
      tick();
      note_err(1'b1);
      for (int k = 0; k < 5; k++) begin
         chk("st.valid", res_valid, 1'b1);
         chk("st.id",    res_id,    1'b0);
         chk("st.flags", {res_even, res_odd, res_err}, 3'b101);
         chk("st.cnt",   err_count, exp_cnt());
         chk("st.rdys",  {req0_ready, req1_ready}, 2'b00);
         tick();
      end
      res_ready = 1'b1;
      tick();
      chk("st.drop",   res_valid,  1'b0);
      chk("st.next1",  req1_ready, 1'b1);
      tick();
      req1_valid = 1'b0;
      tick();
      chk("st.id1",    res_id,     1'b1);
      chk("st.odd1",   res_odd,    1'b1);
      tick();

      // Reset while holding a req1 result, after req0 was served last
      send("pre", 1'b0, 9'h001, 1'b1, 1'b1, 1'b0);
      req1_valid = 1'b1; req1_data = 9'h001; req1_odd = 1'b1; res_ready = 1'b0;
      tick();
      req1_valid = 1'b0;
      tick();
      chk("hr.valid", res_valid, 1'b1);
      chk("hr.id",    res_id,    1'b1);
      rst = 1'b1;
      tick();
      mcnt = 0;
      req0_valid = 1'b1; req1_valid = 1'b1; #1;
      chk("hr.valid0", res_valid, 1'b0);
      chk("hr.cnt0",   err_count, 0);
      chk("hr.rdys",   {req0_ready, req1_ready}, 2'b00);
      rst = 1'b0; #1;
      chk("hr.grant0", req0_ready, 1'b1);
      chk("hr.grant1", req1_ready, 1'b0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Saturation: five mismatching words (counter 1,2,3,3,3 when built)
      for (int k = 0; k < 5; k++)
         send("sat", 1'b0, 9'h001, 1'b0, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_parity_arbiter
